// File: rtl/m_axi_lite_tg_if.sv
// rtl/m_axi_lite_tg_if.sv - AXI4-Lite channel bundle between the traffic generator and a slave
interface m_axi_lite_tg_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [AWIDTH-1:0]     awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [DWIDTH-1:0]     wdata;
   logic [DWIDTH/8-1:0]   wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [AWIDTH-1:0]     araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [DWIDTH-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/m_axi_lite_tg.sv
// rtl/m_axi_lite_tg.sv - AXI4-Lite master traffic generator with deterministic pattern self-check
module m_axi_lite_tg #(
   parameter int                DWIDTH    = 32,
   parameter int                AWIDTH    = 32,
   parameter int                TXN_NUM   = 4,
   parameter int                IDX_BIT   = 16,
   parameter int                CNT_BIT   = 8,
   parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned       ADDR_STEP = 4,
   parameter int unsigned       SEED      = 0
) (
   input  logic               clk,
   input  logic               xrst,
   input  logic               req,
   input  logic [1:0]         mode,
   output logic               ack,
   output logic               busy,
   output logic               err,
   output logic [CNT_BIT-1:0] err_cnt,
   output logic [DWIDTH-1:0]  probe,
   m_axi_lite_tg_if.master    axi
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int PW = (16 + IDX_BIT > DWIDTH) ? DWIDTH - 16 : IDX_BIT;

   state_t              state_q, state_d;
   logic [IDX_BIT-1:0]  idx_q, idx_d;
   logic [1:0]          mode_q, mode_d;
   logic                issued_q, issued_d;
   logic                r_req_q;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [AWIDTH-1:0]   awaddr_q, awaddr_d;
   logic [AWIDTH-1:0]   araddr_q, araddr_d;
   logic [DWIDTH-1:0]   wdata_q, wdata_d;
   logic [CNT_BIT-1:0]  err_cnt_q, err_cnt_d;
   logic                err_q, err_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;

   logic                start;
   logic                last;
   logic                inc_err;
   logic [AWIDTH-1:0]   pat_addr;
   logic [DWIDTH-1:0]   pat_data;
   logic [DWIDTH-1:0]   probe_w;
   logic                unused_resp;

   assign start    = req & ~r_req_q;
   assign last     = (idx_q == IDX_BIT'(TXN_NUM - 1));
   assign pat_addr = BASE_ADDR + AWIDTH'(idx_q) * AWIDTH'(ADDR_STEP);
   assign pat_data = DWIDTH'(SEED) + DWIDTH'(idx_q);

   assign unused_resp = ^{axi.bresp[0], axi.rresp[0]};

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         mode_q    <= 2'd0;
         issued_q  <= 1'b0;
         r_req_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mode_q    <= mode_d;
         issued_q  <= issued_d;
         r_req_q   <= req;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   // issued_q separates the idle gap cycle from the in-flight part of each transaction
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mode_d    = mode_q;
      issued_d  = issued_q;
      awvalid_d = awvalid_q & ~axi.awready;
      wvalid_d  = wvalid_q & ~axi.wready;
      arvalid_d = arvalid_q & ~axi.arready;
      bready_d  = bready_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      err_cnt_d = err_cnt_q;
      ack_d     = ack_q;
      inc_err   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               err_cnt_d = '0;
               ack_d     = 1'b0;
               idx_d     = '0;
               issued_d  = 1'b0;
               mode_d    = mode;
               state_d   = (mode == 2'd2) ? READ : WRITE;
            end
         end
         WRITE: begin
            if (!issued_q) begin
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               bready_d  = 1'b1;
               awaddr_d  = pat_addr;
               wdata_d   = pat_data;
               issued_d  = 1'b1;
            end else if (bready_q && axi.bvalid) begin
               bready_d = 1'b0;
               issued_d = 1'b0;
               inc_err  = axi.bresp[1];
               if (last) begin
                  idx_d   = '0;
                  state_d = (mode_q == 2'd1) ? DONE : READ;
               end else begin
                  idx_d = idx_q + IDX_BIT'(1);
               end
            end
         end
         READ: begin
            if (!issued_q) begin
               arvalid_d = 1'b1;
               rready_d  = 1'b1;
               araddr_d  = pat_addr;
               issued_d  = 1'b1;
            end else if (rready_q && axi.rvalid) begin
               rready_d = 1'b0;
               issued_d = 1'b0;
               inc_err  = axi.rresp[1] | (axi.rdata != pat_data);
               if (last) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_BIT'(1);
               end
            end
         end
      endcase

      if (inc_err && (err_cnt_q != {CNT_BIT{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_BIT'(1);
      end
      if ((state_d == DONE) && (state_q != DONE)) begin
         ack_d = 1'b1;
      end
      busy_d = (state_d == WRITE) || (state_d == READ);
      err_d  = (err_cnt_d != '0);
   end

   always_comb begin
      probe_w          = '0;
      probe_w[1:0]     = state_q;
      probe_w[16 +: PW] = idx_q[PW-1:0];
   end

   assign ack         = ack_q;
   assign busy        = busy_q;
   assign err         = err_q;
   assign err_cnt     = err_cnt_q;
   assign probe       = probe_w;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.awprot  = 3'b000;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = {(DWIDTH/8){1'b1}};
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arprot  = 3'b001;
   assign axi.rready  = rready_q;

endmodule
